scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 9 +
 rtl/step_pacer.sv | 48 ++++
 rtl/scan_sequencer.sv | 134 +++++++++++++
 tb/tb_scan_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, field widths and defaults for the scan sequencer.
package scan_pkg;
  localparam int LINES_W = 16;
  localparam int STEPS_W = 8;
  localparam int SETTLE_W = 16;
  localparam int HOME_W = 16;
  localparam logic [HOME_W-1:0] DEF_MAX_HOME_STEPS = 16'd20000;
  typedef enum logic [2:0] {IDLE, HOME, MOVE, SETTLE, CAPTURE, FINISH, FAULT} scan_state_t;
endpackage

// File: rtl/step_pacer.sv
// step_pacer: issues one step_req at a time, waits for its ack, and counts completed steps toward count.
module step_pacer
  import scan_pkg::*;
(
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              go,
  input  logic              halt,
  input  logic [HOME_W-1:0] count,
  input  logic              step_ack,
  output logic              step_req,
  output logic              finished
);
  logic run_q, run_d, pend_q, pend_d, req_q, req_d;
  logic [HOME_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  always_comb begin
    run_d = go;
    tgt_d = count;
    cnt_d = go ? cnt_q : '0;
    pend_d = go & pend_q;
    req_d = 1'b0;
    if (go && pend_q && step_ack) begin
      pend_d = 1'b0;
      cnt_d = cnt_q + 1'b1;
    end else if (go && !pend_q && !halt && cnt_q != count) begin
      pend_d = 1'b1;
      req_d = 1'b1;
    end
  end
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      pend_q <= 1'b0;
      req_q <= 1'b0;
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      run_q <= run_d;
      pend_q <= pend_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end
  assign step_req = req_q;
  // Depends only on flops and the parent's registered halt, so the parent FSM can consume it without a loop.
  assign finished = run_q & ~pend_q & (halt | (cnt_q == tgt_q));
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: homes the carriage, then for each line steps, settles and enables CCD capture.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter logic [HOME_W-1:0] MAX_HOME_STEPS = DEF_MAX_HOME_STEPS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_100M,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [LINES_W-1:0]  cfg_lines,
  input  logic [STEPS_W-1:0]  cfg_steps,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                mtr_nhome,
  input  logic                mtr_nflt,
  output logic                step_req,
  input  logic                step_ack,
  output logic                step_dir,
  output logic                ccd_en,
  input  logic                line_done,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic [LINES_W-1:0]  line_idx
);
  scan_state_t state_q, state_d;
  logic [LINES_W-1:0] lines_q, lines_d, line_idx_q, line_idx_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [SETTLE_W-1:0] settle_q, settle_d, settle_cnt_q, settle_cnt_d;
  logic [SYNC_STAGES-1:0] nhome_sync_q, nhome_sync_d, nflt_sync_q, nflt_sync_d;
  logic fault_q, fault_d, busy_q, busy_d, done_q, done_d, ccd_en_q, ccd_en_d, step_dir_q, step_dir_d;
  logic zero_done, nhome_s, nflt_s, pace_go, pace_halt, pace_fin;
  logic [HOME_W-1:0] pace_cnt;
  assign nhome_sync_d = (nhome_sync_q << 1) | SYNC_STAGES'(mtr_nhome);
  assign nflt_sync_d = (nflt_sync_q << 1) | SYNC_STAGES'(mtr_nflt);
  assign nhome_s = nhome_sync_q[SYNC_STAGES-1];
  assign nflt_s = nflt_sync_q[SYNC_STAGES-1];
  assign pace_halt = (state_q == HOME) & ~nhome_s;
  always_comb begin
    state_d = state_q;
    lines_d = lines_q;
    steps_d = steps_q;
    settle_d = settle_q;
    settle_cnt_d = settle_cnt_q;
    line_idx_d = line_idx_q;
    fault_d = fault_q;
    zero_done = 1'b0;
    if (abort) state_d = IDLE;
    else if (state_q != IDLE && state_q != FAULT && !nflt_s) state_d = FAULT;
    else begin
      case (state_q)
        IDLE: if (start) begin
          lines_d = cfg_lines;
          steps_d = cfg_steps;
          settle_d = cfg_settle;
          fault_d = 1'b0;
          line_idx_d = '0;
          zero_done = cfg_lines == '0;
          state_d = zero_done ? IDLE : HOME;
        end
        HOME: if (pace_fin) state_d = nhome_s ? FAULT : MOVE;
        MOVE: if (pace_fin) begin
          state_d = SETTLE;
          settle_cnt_d = settle_q;
        end
        SETTLE: begin
          state_d = settle_cnt_q == '0 ? CAPTURE : SETTLE;
          settle_cnt_d = settle_cnt_q == '0 ? settle_cnt_q : settle_cnt_q - 1'b1;
        end
        CAPTURE: if (line_done) begin
          state_d = line_idx_q == lines_q - 1'b1 ? FINISH : MOVE;
          line_idx_d = line_idx_q == lines_q - 1'b1 ? line_idx_q : line_idx_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    fault_d = fault_d | (state_d == FAULT);
    busy_d = state_d != IDLE;
    done_d = (state_d == FINISH) | zero_done;
    ccd_en_d = state_d == CAPTURE;
    step_dir_d = state_d == MOVE;
    // The pacer sits out the first cycle of HOME/MOVE so its step count restarts between phases.
    pace_go = (state_d == HOME || state_d == MOVE) && state_d == state_q;
    pace_cnt = state_d == HOME ? MAX_HOME_STEPS : HOME_W'(steps_q);
  end
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lines_q <= '0;
      steps_q <= '0;
      settle_q <= '0;
      settle_cnt_q <= '0;
      line_idx_q <= '0;
      fault_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ccd_en_q <= 1'b0;
      step_dir_q <= 1'b0;
      nhome_sync_q <= '1;
      nflt_sync_q <= '1;
    end else begin
      state_q <= state_d;
      lines_q <= lines_d;
      steps_q <= steps_d;
      settle_q <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      line_idx_q <= line_idx_d;
      fault_q <= fault_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ccd_en_q <= ccd_en_d;
      step_dir_q <= step_dir_d;
      nhome_sync_q <= nhome_sync_d;
      nflt_sync_q <= nflt_sync_d;
    end
  end
  step_pacer u_pacer (
    .clk_100M(clk_100M),
    .rst(rst),
    .go(pace_go),
    .halt(pace_halt),
    .count(pace_cnt),
    .step_ack(step_ack),
    .step_req(step_req),
    .finished(pace_fin)
  );
  assign step_dir = step_dir_q;
  assign ccd_en = ccd_en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fault = fault_q;
  assign line_idx = line_idx_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and randomized scans against a counting model of the motor/CCD behaviour.
module tb_scan_sequencer;
  localparam int SS = 2;
  logic clk_100M = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [15:0] cfg_lines = '0, cfg_settle = '0;
  logic [7:0] cfg_steps = '0;
  logic mtr_nhome, mtr_nflt = 1'b1, step_req, step_ack = 1'b0, step_dir, ccd_en, line_done = 1'b0;
  logic busy, done, fault;
  logic [15:0] line_idx;
  logic [15:0] idx_log [64];
  int n_assert = 0, n_fail = 0;
  int n_home = 0, n_scan = 0, n_win = 0, n_done = 0, viol = 0;
  int home_base = 0, home_at = 0, ack_dly = 3, cap_dly = 2, cur_lines = 0;
  int cyc = 0, wait_n = 0, last_ack = -10, ld_wait = 0;
  bit abort_last = 1'b0, ccd_prev = 1'b0;
  int h0, s0, w0, d0, r0;
  bit got;

  always #5 clk_100M = ~clk_100M;

  // The home switch closes during the home_at-th homing step of the current scan.
  assign mtr_nhome = (n_home - home_base) < home_at;

  scan_sequencer #(.MAX_HOME_STEPS(16'd5), .SYNC_STAGES(SS)) dut (
    .clk_100M(clk_100M), .rst(rst), .start(start), .abort(abort),
    .cfg_lines(cfg_lines), .cfg_steps(cfg_steps), .cfg_settle(cfg_settle),
    .mtr_nhome(mtr_nhome), .mtr_nflt(mtr_nflt), .step_req(step_req), .step_ack(step_ack),
    .step_dir(step_dir), .ccd_en(ccd_en), .line_done(line_done), .busy(busy), .done(done),
    .fault(fault), .line_idx(line_idx)
  );

  // Motor driver model: acks each request ack_dly cycles later and flags handshake rule breaks.
  initial forever begin
    @(negedge clk_100M);
    cyc++;
    if (step_ack) last_ack = cyc - 1;
    if (step_req && (wait_n > 0 || cyc - last_ack < 2)) viol++;
    step_ack = 1'b0;
    if (wait_n > 0) begin
      wait_n--;
      if (wait_n == 0) step_ack = 1'b1;
    end
    if (step_req) begin
      if (step_dir) n_scan++;
      else n_home++;
      wait_n = ack_dly;
    end
  end

  // CCD model: logs each capture window and ends it cap_dly cycles later.
  initial forever begin
    @(negedge clk_100M);
    line_done = 1'b0;
    abort = 1'b0;
    if (done) n_done++;
    if (ccd_en && !ccd_prev) begin
      idx_log[6'(n_win)] = line_idx;
      n_win++;
      ld_wait = cap_dly;
    end else if (ccd_en && ld_wait > 0) begin
      ld_wait--;
      if (ld_wait == 0) begin
        line_done = 1'b1;
        if (abort_last && int'(line_idx) == cur_lines - 1) abort = 1'b1;
      end
    end
    ccd_prev = ccd_en;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_100M);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setup(input int hat, input int ad, input int cd, input int lines);
    ack_dly = ad;
    cap_dly = cd;
    cur_lines = lines;
    home_at = hat;
    home_base = n_home;
    tick(1);
    h0 = n_home;
    s0 = n_scan;
    w0 = n_win;
    d0 = n_done;
    r0 = n_home + n_scan;
  endtask

  task automatic kick(input int lines, input int steps, input int settle);
    cfg_lines = 16'(lines);
    cfg_steps = 8'(steps);
    cfg_settle = 16'(settle);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic run_scan(input string tag, input int lines, input int steps, input int settle,
                          input int hat, input int ad, input int cd);
    int v0;
    setup(hat, ad, cd, lines);
    v0 = viol;
    kick(lines, steps, settle);
    chk({tag, " fault cleared"}, 32'(fault), 0);
    chk({tag, " busy"}, 32'(busy), 1);
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else tick(1);
    end
    chk({tag, " done seen"}, 32'(got), 1);
    chk({tag, " busy at done"}, 32'(busy), 1);
    chk({tag, " home steps"}, n_home - h0, hat);
    chk({tag, " scan steps"}, n_scan - s0, lines * steps);
    chk({tag, " windows"}, n_win - w0, lines);
    for (int i = 0; i < lines; i++) chk($sformatf("%s idx%0d", tag, i), 32'(idx_log[6'(w0 + i)]), i);
    chk({tag, " final line_idx"}, 32'(line_idx), lines - 1);
    chk({tag, " handshake gaps"}, viol - v0, 0);
    tick(1);
    chk({tag, " done width"}, 32'(done), 0);
    chk({tag, " idle busy"}, 32'(busy), 0);
    chk({tag, " done count"}, n_done - d0, 1);
    chk({tag, " no fault"}, 32'(fault), 0);
  endtask

  initial begin
    tick(2);
    chk("rst step_req", 32'(step_req), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst fault", 32'(fault), 0);
    chk("rst ccd_en", 32'(ccd_en), 0);
    chk("rst line_idx", 32'(line_idx), 0);
    rst = 1'b0;
    tick(3);
    run_scan("basic", 3, 4, 10, 2, 3, 2);
    for (int k = 0; k < 4; k++)
      run_scan($sformatf("rand%0d", k), int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), int'($urandom_range(1, 4)),
               int'($urandom_range(1, 5)));
    setup(1, 2, 2, 0);
    kick(0, 3, 3);
    chk("zero done", 32'(done), 1);
    chk("zero busy", 32'(busy), 0);
    tick(1);
    chk("zero done width", 32'(done), 0);
    tick(5);
    chk("zero no steps", n_home + n_scan - r0, 0);
    chk("zero done count", n_done - d0, 1);
    setup(1000, 2, 2, 1);
    kick(1, 1, 0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (fault === 1'b1) got = 1'b1;
      else tick(1);
    end
    chk("nohome fault seen", 32'(got), 1);
    chk("nohome busy in fault", 32'(busy), 1);
    chk("nohome steps", n_home - h0, 5);
    tick(1);
    chk("nohome idle", 32'(busy), 0);
    chk("nohome fault held", 32'(fault), 1);
    tick(5);
    chk("nohome no more steps", n_home - h0, 5);
    chk("nohome no done", n_done - d0, 0);
    setup(1, 2, 2, 3);
    kick(3, 4, 3);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (n_win - w0 == 1 && n_scan - s0 == 5) got = 1'b1;
      else tick(1);
    end
    chk("nflt reached move2", 32'(got), 1);
    mtr_nflt = 1'b0;
    tick(SS + 1);
    r0 = n_home + n_scan;
    chk("nflt fault", 32'(fault), 1);
    chk("nflt busy", 32'(busy), 1);
    chk("nflt step_req", 32'(step_req), 0);
    chk("nflt ccd_en", 32'(ccd_en), 0);
    tick(1);
    chk("nflt idle", 32'(busy), 0);
    chk("nflt fault held", 32'(fault), 1);
    tick(10);
    chk("nflt steps stopped", n_home + n_scan - r0, 0);
    chk("nflt no window", n_win - w0, 1);
    chk("nflt no done", n_done - d0, 0);
    mtr_nflt = 1'b1;
    tick(4);
    abort_last = 1'b1;
    setup(1, 1, 2, 2);
    kick(2, 1, 1);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (abort === 1'b1) got = 1'b1;
      else tick(1);
    end
    chk("abort seen", 32'(got), 1);
    chk("abort last line", 32'(line_idx), 1);
    chk("abort ccd before", 32'(ccd_en), 1);
    tick(1);
    chk("abort ccd_en", 32'(ccd_en), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    tick(5);
    chk("abort no done", n_done - d0, 0);
    abort_last = 1'b0;
    setup(1, 2, 2, 2);
    kick(2, 2, 40);
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      if (n_scan - s0 == 2) got = 1'b1;
      else tick(1);
    end
    chk("rst reached move", 32'(got), 1);
    tick(8);
    chk("settle busy", 32'(busy), 1);
    chk("settle dir", 32'(step_dir), 0);
    rst = 1'b1;
    tick(1);
    chk("midrst step_req", 32'(step_req), 0);
    chk("midrst step_dir", 32'(step_dir), 0);
    chk("midrst ccd_en", 32'(ccd_en), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst fault", 32'(fault), 0);
    chk("midrst line_idx", 32'(line_idx), 0);
    rst = 1'b0;
    r0 = n_home + n_scan;
    tick(10);
    chk("postrst no steps", n_home + n_scan - r0, 0);
    chk("postrst idle", 32'(busy), 0);
    chk("postrst no done", n_done - d0, 0);
    run_scan("after rst", 1, 3, 2, 1, 2, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
